// File: rtl/systolic_mac_pe_pkg.sv
// rtl/systolic_mac_pe_pkg.sv - shared state type and saturating add for the systolic MAC PE
package systolic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } pe_state_t;

  // Working width for the add; wide enough for any ACC_W up to 63 bits.
  localparam int SAT_W = 64;

  // Operands arrive already sign- or zero-extended to SAT_W bits, so the sum is exact.
  // Returns {ovf, sum}; only the low acc_w bits of sum are meaningful to the caller.
  function automatic logic [SAT_W:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] prod,
    input int unsigned      acc_w,
    input logic             is_signed,
    input logic             saturate
  );
    logic [SAT_W-1:0] sum;
    logic [SAT_W-1:0] umax;
    logic [SAT_W-1:0] smax;
    logic [SAT_W-1:0] smin;
    logic             ovf;
    sum  = acc + prod;
    umax = (SAT_W'(1) << acc_w) - SAT_W'(1);
    smax = (SAT_W'(1) << (acc_w - 1)) - SAT_W'(1);
    // Bitwise inverse of the positive limit is the sign-extended negative limit.
    smin = ~smax;
    if (is_signed) begin
      ovf = ($signed(sum) > $signed(smax)) || ($signed(sum) < $signed(smin));
    end else begin
      ovf = (sum > umax);
    end
    if (ovf && saturate) begin
      if (!is_signed) begin
        sum = umax;
      end else if (sum[SAT_W-1]) begin
        sum = smin;
      end else begin
        sum = smax;
      end
    end
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/systolic_mac_pe_if.sv
// rtl/systolic_mac_pe_if.sv - operand, clear and partial-sum link between neighbouring PEs
interface systolic_mac_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic [DATA_W-1:0] a;
  logic              a_valid;
  logic              clear;
  logic [DATA_W-1:0] b;
  logic              b_valid;
  logic [ACC_W-1:0]  psum;
  logic              psum_valid;
  logic              psum_last;

  modport master (
    output a, a_valid, clear, b, b_valid, psum, psum_valid, psum_last
  );

  modport slave (
    input a, a_valid, clear, b, b_valid, psum, psum_valid, psum_last
  );
endinterface

// File: rtl/systolic_mac_pe_mac_sat_unit.sv
// rtl/systolic_mac_pe_mac_sat_unit.sv - combinational multiply, accumulate, overflow detect and clamp
module mac_sat_unit
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              fire_i,
  input  logic              clear_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  acc_next_o,
  output logic              ovf_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [SAT_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  base;
  logic [SAT_W-1:0]  base_ext;
  logic [SAT_W:0]    res;
  logic              unused_res_hi;

  // Full-width product, then extended to the working width according to signedness
  always_comb begin
    if (SIGNED != 0) begin
      prod     = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
      prod_ext = SAT_W'($signed(prod));
    end else begin
      prod     = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
      prod_ext = SAT_W'(prod);
    end
  end

  // Clear restarts the tile from zero; without a fire the accumulator simply holds
  always_comb begin
    base = clear_i ? '0 : acc_i;
    if (SIGNED != 0) begin
      base_ext = SAT_W'($signed(base));
    end else begin
      base_ext = SAT_W'(base);
    end
    res        = sat_add(base_ext, prod_ext, ACC_W, SIGNED != 0, SATURATE != 0);
    acc_next_o = fire_i ? res[ACC_W-1:0] : acc_i;
    ovf_o      = fire_i & res[SAT_W];
  end

  assign unused_res_hi = ^res[SAT_W-1:ACC_W];

endmodule

// File: rtl/systolic_mac_pe.sv
// rtl/systolic_mac_pe.sv - output-stationary systolic MAC processing element with drain chain
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  systolic_mac_pe_if.slave  up_i,
  systolic_mac_pe_if.master dn_o,
  input  logic              drain_i,
  input  logic              chain_head_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              drain_err_o
);

  pe_state_t         state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic              a_valid_q, b_valid_q, clear_q;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic              psum_valid_q, psum_valid_d;
  logic              psum_last_q, psum_last_d;
  logic              overflow_q, overflow_d;
  logic              drain_err_q, drain_err_d;
  logic              fire;
  logic              mac_ovf;

  assign fire = up_i.a_valid & up_i.b_valid;

  mac_sat_unit #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_mac (
    .a_i        (up_i.a),
    .b_i        (up_i.b),
    .fire_i     (fire),
    .clear_i    (up_i.clear),
    .acc_i      (acc_q),
    .acc_next_o (acc_next),
    .ovf_o      (mac_ovf)
  );

  // Operand forwarding: unconditional one-cycle copies to east and south neighbours
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      clear_q   <= 1'b0;
      b_q       <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_q       <= up_i.a;
      a_valid_q <= up_i.a_valid;
      clear_q   <= up_i.clear;
      b_q       <= up_i.b;
      b_valid_q <= up_i.b_valid;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a non-head drain enters PASS until the upstream last beat goes by
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drain_i && !chain_head_i) state_d = PASS;
      PASS:    if (up_i.psum_valid && up_i.psum_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: own drain beat in IDLE, transparent forwarding in PASS, quiet otherwise
  always_comb begin
    psum_d       = '0;
    psum_valid_d = 1'b0;
    psum_last_d  = 1'b0;
    acc_d        = acc_next;
    case (state_q)
      IDLE: begin
        if (drain_i) begin
          psum_d       = acc_next;
          psum_valid_d = 1'b1;
          psum_last_d  = chain_head_i;
          acc_d        = '0;
        end
      end
      PASS: begin
        psum_d       = up_i.psum;
        psum_valid_d = up_i.psum_valid;
        psum_last_d  = up_i.psum_last;
      end
      default: ;
    endcase
    overflow_d  = overflow_q | mac_ovf;
    drain_err_d = drain_err_q | (drain_i && (state_q == PASS));
  end

  // Accumulator, partial-sum output registers and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      psum_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drain_err_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      psum_last_q  <= psum_last_d;
      overflow_q   <= overflow_d;
      drain_err_q  <= drain_err_d;
    end
  end

  assign dn_o.a          = a_q;
  assign dn_o.a_valid    = a_valid_q;
  assign dn_o.clear      = clear_q;
  assign dn_o.b          = b_q;
  assign dn_o.b_valid    = b_valid_q;
  assign dn_o.psum       = psum_q;
  assign dn_o.psum_valid = psum_valid_q;
  assign dn_o.psum_last  = psum_last_q;
  assign busy_o          = (state_q != IDLE);
  assign overflow_o      = overflow_q;
  assign drain_err_o     = drain_err_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb/tb_systolic_mac_pe.sv - directed self-checking bench for systolic_mac_pe
module tb_systolic_mac_pe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24)) up_u ();
  systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24)) dn_u ();
  systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24)) up_s ();
  systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24)) dn_s ();

  logic drain_u, head_u, busy_u, ovf_u, derr_u;
  logic drain_s, head_s, busy_s, ovf_s, derr_s;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(0), .SATURATE(1)) dut_u (
    .clk(clk), .rst(rst), .up_i(up_u), .dn_o(dn_u), .drain_i(drain_u), .chain_head_i(head_u),
    .busy_o(busy_u), .overflow_o(ovf_u), .drain_err_o(derr_u)
  );

  systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .up_i(up_s), .dn_o(dn_s), .drain_i(drain_s), .chain_head_i(head_s),
    .busy_o(busy_s), .overflow_o(ovf_s), .drain_err_o(derr_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_u();
    up_u.a = '0; up_u.a_valid = 1'b0; up_u.clear = 1'b0; up_u.b = '0; up_u.b_valid = 1'b0;
    up_u.psum = '0; up_u.psum_valid = 1'b0; up_u.psum_last = 1'b0; drain_u = 1'b0;
  endtask

  task automatic idle_s();
    up_s.a = '0; up_s.a_valid = 1'b0; up_s.clear = 1'b0; up_s.b = '0; up_s.b_valid = 1'b0;
    up_s.psum = '0; up_s.psum_valid = 1'b0; up_s.psum_last = 1'b0; drain_s = 1'b0;
  endtask

  task automatic beat_u(input logic [7:0] a, input logic [7:0] b, input logic clr);
    up_u.a = a; up_u.b = b; up_u.a_valid = 1'b1; up_u.b_valid = 1'b1; up_u.clear = clr;
    tick();
    idle_u();
  endtask

  task automatic beat_s(input logic [7:0] a, input logic [7:0] b, input logic clr);
    up_s.a = a; up_s.b = b; up_s.a_valid = 1'b1; up_s.b_valid = 1'b1; up_s.clear = clr;
    tick();
    idle_s();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_u(); idle_s(); head_u = 1'b1; head_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({dn_u.a, dn_u.a_valid, dn_u.clear, dn_u.b, dn_u.b_valid, dn_u.psum, dn_u.psum_valid, dn_u.psum_last} !== '0) begin
      $display("FAIL reset_u_outputs got psum=%0h a=%0h b=%0h exp 0", dn_u.psum, dn_u.a, dn_u.b); errors++;
    end
    checks++;
    if ({busy_u, ovf_u, derr_u} !== 3'b000) begin
      $display("FAIL reset_u_flags got %b exp 000", {busy_u, ovf_u, derr_u}); errors++;
    end
    checks++;
    if ({dn_s.psum, dn_s.psum_valid, dn_s.psum_last, busy_s, ovf_s, derr_s} !== '0) begin
      $display("FAIL reset_s_outputs got psum=%0h flags=%b exp 0", dn_s.psum, {busy_s, ovf_s, derr_s}); errors++;
    end
    checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    head_u = 1'b1;
    up_u.a = 8'hA5; up_u.a_valid = 1'b1; up_u.clear = 1'b1; up_u.b = 8'h3C; up_u.b_valid = 1'b0;
    tick();
    if (dn_u.a !== 8'hA5) begin $display("FAIL fwd_a got %0h exp a5", dn_u.a); errors++; end
    checks++;
    if (dn_u.b !== 8'h3C) begin $display("FAIL fwd_b got %0h exp 3c", dn_u.b); errors++; end
    checks++;
    if ({dn_u.a_valid, dn_u.clear, dn_u.b_valid} !== 3'b110) begin
      $display("FAIL fwd_flags1 got %b exp 110", {dn_u.a_valid, dn_u.clear, dn_u.b_valid}); errors++;
    end
    checks++;
    idle_u(); up_u.b_valid = 1'b1;
    tick();
    if ({dn_u.a_valid, dn_u.clear, dn_u.b_valid} !== 3'b001) begin
      $display("FAIL fwd_flags2 got %b exp 001", {dn_u.a_valid, dn_u.clear, dn_u.b_valid}); errors++;
    end
    checks++;
    idle_u(); drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd0 || dn_u.psum_valid !== 1'b1) begin
      $display("FAIL fwd_single_valid_acc got %0d/%b exp 0/1", dn_u.psum, dn_u.psum_valid); errors++;
    end
    checks++;
  endtask

  task automatic test_basic_drain();
    head_u = 1'b1;
    beat_u(8'd2, 8'd2, 1'b0);
    beat_u(8'd3, 8'd3, 1'b1);
    up_u.a = 8'd7; up_u.a_valid = 1'b1; up_u.clear = 1'b1;
    tick();
    idle_u();
    beat_u(8'd4, 8'd4, 1'b0);
    drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd25) begin $display("FAIL basic_psum got %0d exp 25", dn_u.psum); errors++; end
    checks++;
    if ({dn_u.psum_valid, dn_u.psum_last, busy_u} !== 3'b110) begin
      $display("FAIL basic_valid_last_busy got %b exp 110", {dn_u.psum_valid, dn_u.psum_last, busy_u}); errors++;
    end
    checks++;
    tick();
    if ({dn_u.psum_valid, dn_u.psum_last} !== 2'b00) begin
      $display("FAIL basic_one_cycle got %b exp 00", {dn_u.psum_valid, dn_u.psum_last}); errors++;
    end
    checks++;
    drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd0 || dn_u.psum_valid !== 1'b1) begin
      $display("FAIL basic_acc_cleared got %0d/%b exp 0/1", dn_u.psum, dn_u.psum_valid); errors++;
    end
    checks++;
  endtask

  task automatic test_saturate();
    head_u = 1'b1;
    up_u.a = 8'd255; up_u.b = 8'd255; up_u.a_valid = 1'b1; up_u.b_valid = 1'b1; up_u.clear = 1'b1;
    for (int i = 0; i < 258; i++) begin tick(); up_u.clear = 1'b0; end
    idle_u();
    if (ovf_u !== 1'b0) begin $display("FAIL sat_258_ovf got %b exp 0", ovf_u); errors++; end
    checks++;
    drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd16776450) begin $display("FAIL sat_258_acc got %0d exp 16776450", dn_u.psum); errors++; end
    checks++;
    up_u.a = 8'd255; up_u.b = 8'd255; up_u.a_valid = 1'b1; up_u.b_valid = 1'b1; up_u.clear = 1'b1;
    for (int i = 0; i < 259; i++) begin tick(); up_u.clear = 1'b0; end
    idle_u();
    if (ovf_u !== 1'b1) begin $display("FAIL sat_259_ovf got %b exp 1", ovf_u); errors++; end
    checks++;
    drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd16777215) begin $display("FAIL sat_259_clamp got %0d exp 16777215", dn_u.psum); errors++; end
    checks++;
  endtask

  task automatic test_drain_chain();
    head_u = 1'b0;
    beat_u(8'd7, 8'd1, 1'b1);
    up_u.psum = 24'd99; up_u.psum_valid = 1'b1; up_u.psum_last = 1'b1;
    tick();
    idle_u();
    if ({dn_u.psum_valid, busy_u} !== 2'b00) begin
      $display("FAIL chain_idle_drop got %b exp 00", {dn_u.psum_valid, busy_u}); errors++;
    end
    checks++;
    drain_u = 1'b1;
    tick();
    idle_u();
    if ({dn_u.psum, dn_u.psum_valid, dn_u.psum_last, busy_u} !== {24'd7, 3'b101}) begin
      $display("FAIL chain_beat0 got %0d/%b exp 7/101", dn_u.psum, {dn_u.psum_valid, dn_u.psum_last, busy_u}); errors++;
    end
    checks++;
    up_u.psum = 24'd9; up_u.psum_valid = 1'b1;
    tick();
    idle_u();
    if ({dn_u.psum, dn_u.psum_valid, dn_u.psum_last, busy_u} !== {24'd9, 3'b101}) begin
      $display("FAIL chain_beat1 got %0d/%b exp 9/101", dn_u.psum, {dn_u.psum_valid, dn_u.psum_last, busy_u}); errors++;
    end
    checks++;
    tick();
    if ({dn_u.psum_valid, busy_u} !== 2'b01) begin
      $display("FAIL chain_gap got %b exp 01", {dn_u.psum_valid, busy_u}); errors++;
    end
    checks++;
    up_u.psum = 24'd11; up_u.psum_valid = 1'b1; up_u.psum_last = 1'b1;
    tick();
    idle_u();
    if ({dn_u.psum, dn_u.psum_valid, dn_u.psum_last} !== {24'd11, 2'b11}) begin
      $display("FAIL chain_beat2 got %0d/%b exp 11/11", dn_u.psum, {dn_u.psum_valid, dn_u.psum_last}); errors++;
    end
    checks++;
    if (busy_u !== 1'b0) begin $display("FAIL chain_busy_drop got %b exp 0", busy_u); errors++; end
    checks++;
    tick();
    if (dn_u.psum_valid !== 1'b0) begin $display("FAIL chain_quiet got %b exp 0", dn_u.psum_valid); errors++; end
    checks++;
  endtask

  task automatic test_mac_and_drain();
    head_u = 1'b0;
    beat_u(8'd5, 8'd2, 1'b1);
    up_u.a = 8'd5; up_u.b = 8'd5; up_u.a_valid = 1'b1; up_u.b_valid = 1'b1; drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd35) begin $display("FAIL macdrain_psum got %0d exp 35", dn_u.psum); errors++; end
    checks++;
    if ({dn_u.psum_valid, dn_u.psum_last, busy_u, derr_u} !== 4'b1010) begin
      $display("FAIL macdrain_flags got %b exp 1010", {dn_u.psum_valid, dn_u.psum_last, busy_u, derr_u}); errors++;
    end
    checks++;
    up_u.a = 8'd2; up_u.b = 8'd3; up_u.a_valid = 1'b1; up_u.b_valid = 1'b1; drain_u = 1'b1;
    tick();
    idle_u();
    if ({derr_u, dn_u.psum_valid, busy_u} !== 3'b101) begin
      $display("FAIL macdrain_err got %b exp 101", {derr_u, dn_u.psum_valid, busy_u}); errors++;
    end
    checks++;
    up_u.psum = 24'd1; up_u.psum_valid = 1'b1; up_u.psum_last = 1'b1;
    tick();
    idle_u();
    if (busy_u !== 1'b0) begin $display("FAIL macdrain_pass_end got %b exp 0", busy_u); errors++; end
    checks++;
    head_u = 1'b1; drain_u = 1'b1;
    tick();
    idle_u();
    if (dn_u.psum !== 24'd6) begin $display("FAIL macdrain_next_tile got %0d exp 6", dn_u.psum); errors++; end
    checks++;
  endtask

  task automatic test_reset_mid_pass();
    head_u = 1'b0;
    beat_u(8'd3, 8'd3, 1'b1);
    drain_u = 1'b1;
    tick();
    idle_u();
    up_u.psum = 24'd5; up_u.psum_valid = 1'b1; up_u.a = 8'h11; up_u.a_valid = 1'b1;
    tick();
    if ({dn_u.psum, dn_u.a, busy_u} !== {24'd5, 8'h11, 1'b1}) begin
      $display("FAIL rstpass_pre got %0d/%0h/%b exp 5/11/1", dn_u.psum, dn_u.a, busy_u); errors++;
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if ({dn_u.a, dn_u.a_valid, dn_u.clear, dn_u.b, dn_u.b_valid, dn_u.psum, dn_u.psum_valid, dn_u.psum_last} !== '0) begin
      $display("FAIL rstpass_outputs got psum=%0d a=%0h valid=%b exp 0", dn_u.psum, dn_u.a, dn_u.psum_valid); errors++;
    end
    checks++;
    if ({busy_u, ovf_u, derr_u} !== 3'b000) begin
      $display("FAIL rstpass_flags got %b exp 000", {busy_u, ovf_u, derr_u}); errors++;
    end
    checks++;
    idle_u();
    tick();
    rst = 1'b0;
    head_u = 1'b1; drain_u = 1'b1;
    tick();
    idle_u();
    if ({dn_u.psum, dn_u.psum_valid, dn_u.psum_last} !== {24'd0, 2'b11}) begin
      $display("FAIL rstpass_next_drain got %0d/%b exp 0/11", dn_u.psum, {dn_u.psum_valid, dn_u.psum_last}); errors++;
    end
    checks++;
  endtask

  task automatic test_signed();
    head_s = 1'b1;
    beat_s(8'hFE, 8'd3, 1'b1);
    for (int i = 0; i < 3; i++) beat_s(8'hFE, 8'd3, 1'b0);
    drain_s = 1'b1;
    tick();
    idle_s();
    if (dn_s.psum !== 24'hFFFFE8) begin $display("FAIL signed_neg24 got %0h exp ffffe8", dn_s.psum); errors++; end
    checks++;
    if ({dn_s.psum_valid, dn_s.psum_last, ovf_s} !== 3'b110) begin
      $display("FAIL signed_flags got %b exp 110", {dn_s.psum_valid, dn_s.psum_last, ovf_s}); errors++;
    end
    checks++;
    beat_s(8'h80, 8'h80, 1'b1);
    drain_s = 1'b1;
    tick();
    idle_s();
    if (dn_s.psum !== 24'h004000) begin $display("FAIL signed_min_sq got %0h exp 004000", dn_s.psum); errors++; end
    checks++;
    beat_s(8'h80, 8'h7F, 1'b1);
    drain_s = 1'b1;
    tick();
    idle_s();
    if (dn_s.psum !== 24'hFFC080) begin $display("FAIL signed_min_max got %0h exp ffc080", dn_s.psum); errors++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_basic_drain();
    test_saturate();
    test_drain_chain();
    test_mac_and_drain();
    test_reset_mid_pass();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
